// File: rtl/tow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tow_pkg
// Brief    : Shared types and constants for the tug-of-war game controller.
//            Optional feature macro used by the controller: TOW_CPU_PLAYER_EN.
// Revision : 1.0 - initial release
// ============================================================================
package tow_pkg;

  // Controller phases: live play, post-win display hold, final game-over
  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    WIN_HOLD  = 2'd1,
    GAME_OVER = 2'd2
  } tow_state_t;

  // Winner indicator as presented on the winner port
  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_RIGHT = 2'b01,
    WIN_LEFT  = 2'b10
  } tow_winner_t;

  localparam logic [9:0] LFSR_SEED = 10'h001;

  // 10-bit Fibonacci LFSR step, taps at bits 10 and 7 (1-based)
  function automatic logic [9:0] lfsr_next(input logic [9:0] cur);
    return {cur[8:0], cur[9] ^ cur[6]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tow_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : tow_edge_detect
// Brief    : Rising-edge detector for one already-synchronized button level.
//            pulse is high for the cycle in which level is 1 and was 0 at the
//            previous clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tow_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // Remember the level seen at the previous edge; cleared by reset so a
  // button held through reset release registers as one press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule
`default_nettype wire

// File: rtl/tow_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tow_game_ctrl
// Brief    : Tug-of-war controller. Edge-detects both player buttons, moves
//            the single lit light, scores wins, holds the win display and
//            restarts rounds. Define TOW_CPU_PLAYER_EN to replace the right
//            player with an LFSR-driven CPU opponent (adds port cpu_speed).
// Revision : 1.0 - initial release
// ============================================================================
module tow_game_ctrl #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3,
  parameter int WIN_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  input  logic                  restart,
`ifdef TOW_CPU_PLAYER_EN
  input  logic [3:0]            cpu_speed,
`endif
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]    left_score,
  output logic [SCORE_W-1:0]    right_score,
  output logic [1:0]            winner,
  output logic                  game_over
);

  import tow_pkg::*;

  localparam int                    CENTRE       = NUM_LIGHTS / 2;
  localparam logic [NUM_LIGHTS-1:0] CENTRE_LIGHT = NUM_LIGHTS'(1) << CENTRE;
  localparam logic [SCORE_W-1:0]    SCORE_MAX    = '1;
  localparam int                    HOLD_W       = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;
  localparam logic [HOLD_W-1:0]     HOLD_LOAD    = HOLD_W'(WIN_HOLD - 1);

  tow_state_t        state;
  tow_state_t        state_nxt;
  tow_winner_t       win_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              lp;
  logic              rp;
  logic              move_left;
  logic              move_right;
  logic              hold_done;
  logic              winner_at_max;

  // ---------------------------------------------------------------- presses
  tow_edge_detect u_edge_left (
    .clk   (clk),
    .reset (reset),
    .level (L),
    .pulse (lp)
  );

`ifdef TOW_CPU_PLAYER_EN
  logic [9:0] lfsr;

  // Free-running pseudo-random source for the CPU player
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Higher cpu_speed widens the window of LFSR values that count as a press
  assign rp = (lfsr[3:0] < cpu_speed);
`else
  tow_edge_detect u_edge_right (
    .clk   (clk),
    .reset (reset),
    .level (R),
    .pulse (rp)
  );
`endif

  // Simultaneous presses cancel each other
  assign move_left  = lp & ~rp;
  assign move_right = rp & ~lp;

  assign hold_done     = (hold_cnt == '0);
  assign winner_at_max = (win_q == WIN_LEFT) ? (left_score == SCORE_MAX)
                                             : (right_score == SCORE_MAX);

  // ------------------------------------------------------------------- FSM
  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= PLAY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; restart overrides everything else
  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = PLAY;
    end else begin
      case (state)
        PLAY: begin
          if ((move_left && lights[NUM_LIGHTS-1]) || (move_right && lights[0])) begin
            state_nxt = tow_pkg::WIN_HOLD;
          end
        end
        tow_pkg::WIN_HOLD: begin
          if (hold_done) begin
            state_nxt = winner_at_max ? GAME_OVER : PLAY;
          end
        end
        GAME_OVER: state_nxt = GAME_OVER;
        default:   state_nxt = PLAY;
      endcase
    end
  end

  // Output decode
  always_comb begin
    winner    = win_q;
    game_over = (state == GAME_OVER);
  end

  // -------------------------------------------------------------- datapath
  // Playfield, scores, winner and hold timer follow the current state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lights      <= CENTRE_LIGHT;
      left_score  <= '0;
      right_score <= '0;
      win_q       <= WIN_NONE;
      hold_cnt    <= '0;
    end else if (restart) begin
      lights      <= CENTRE_LIGHT;
      left_score  <= '0;
      right_score <= '0;
      win_q       <= WIN_NONE;
      hold_cnt    <= '0;
    end else begin
      case (state)
        PLAY: begin
          if (move_left) begin
            if (lights[NUM_LIGHTS-1]) begin
              lights   <= '0;
              win_q    <= WIN_LEFT;
              hold_cnt <= HOLD_LOAD;
              if (left_score != SCORE_MAX) begin
                left_score <= left_score + SCORE_W'(1);
              end
            end else begin
              lights <= lights << 1;
            end
          end else if (move_right) begin
            if (lights[0]) begin
              lights   <= '0;
              win_q    <= WIN_RIGHT;
              hold_cnt <= HOLD_LOAD;
              if (right_score != SCORE_MAX) begin
                right_score <= right_score + SCORE_W'(1);
              end
            end else begin
              lights <= lights >> 1;
            end
          end
        end
        tow_pkg::WIN_HOLD: begin
          if (hold_done) begin
            // On game over the winner stays on display and the row stays dark
            if (!winner_at_max) begin
              lights <= CENTRE_LIGHT;
              win_q  <= WIN_NONE;
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        GAME_OVER: begin
          lights <= '0;
        end
        default: begin
          lights <= CENTRE_LIGHT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
